conv_window_gen: RTL

Multi-channel sliding-window generator that sits directly upstream of the multi-channel multiply-accumulate stage. It accepts a raster-order pixel stream, with all input channels of one pixel in parallel. It buffers KERNEL_SIZE-1 image rows per channel and emits a packed KERNEL_SIZE x KERNEL_SIZE window for every channel, with a valid strobe. Stride 1, no padding ("valid" convolution), no backpressure: the downstream MAC accepts one window per cycle.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/conv_window_gen_if.sv | 28 ++
 rtl/conv_window_gen_line_buffer.sv | 33 +++
 rtl/conv_window_gen.sv | 88 ++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and window-packing helper for the window generator, MAC stage and benches.
//   WIN_ELEMS   elements per channel window (KERNEL_SIZE^2)
//   win_idx()   bit offset of element (ch, r, c) in a packed window bus
package cnn_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_IN_CHANNEL  = 3;
    localparam int DEF_IMG_WIDTH   = 8;
    localparam int DEF_IMG_HEIGHT  = 8;
    localparam int WIN_ELEMS       = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

    // r=0 is the oldest (top) row, c=0 the oldest (left) column
    function automatic int win_idx(input int ch, input int r, input int c);
        return (ch * WIN_ELEMS + r * DEF_KERNEL_SIZE + c) * DEF_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bundle of the window generator.
//   master: pixel source side (drives pixel_valid, pixel_in)
//   slave:  window generator side (drives window_valid, window_out, frame_done)
interface conv_window_gen_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IN_CHANNEL  = DEF_IN_CHANNEL
);

    logic                                                    pixel_valid;
    logic [IN_CHANNEL*DATA_WIDTH-1:0]                        pixel_in;
    logic                                                    window_valid;
    logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out;
    logic                                                    frame_done;

    modport master (
        output pixel_valid, pixel_in,
        input  window_valid, window_out, frame_done
    );

    modport slave (
        input  pixel_valid, pixel_in,
        output window_valid, window_out, frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one-channel, one-row delay of IMG_WIDTH pixels with a circular pointer.
//   clk, rst_n  clock, async active-low reset (pointer only; storage is not reset)
//   en          advance by one pixel
//   din, dout   pixel in, pixel written IMG_WIDTH accepted pixels earlier
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
    logic [PW-1:0]         ptr;

    // read-before-write at the same slot gives exactly one row of delay
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) mem[ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (en) ptr <= ptr == PW'(IMG_WIDTH - 1) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to per-channel KxK sliding windows (stride 1, no padding).
//   clk, rst_n  clock, async active-low reset
//   bus         slave side of conv_window_gen_if: pixel_valid/pixel_in in,
//               window_valid/window_out/frame_done out (all outputs registered)
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IN_CHANNEL  = DEF_IN_CHANNEL,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
    input logic              clk,
    input logic              rst_n,
    conv_window_gen_if.slave bus
);

    localparam int DW = DATA_WIDTH;
    localparam int K  = KERNEL_SIZE;
    localparam int C  = IN_CHANNEL;
    localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [DW-1:0]       tap    [C][K];
    logic [DW-1:0]       win    [C][K][K];
    logic [DW-1:0]       win_nx [C][K][K];
    logic [C*K*K*DW-1:0] win_flat;
    logic                accept, last_col, last_row, win_hit;

    assign accept   = bus.pixel_valid;
    assign last_col = col == CW'(IMG_WIDTH - 1);
    assign last_row = row == RW'(IMG_HEIGHT - 1);
    // the column gate also rejects windows that would straddle a row wrap
    assign win_hit  = accept && int'(row) >= K - 1 && int'(col) >= K - 1;

    // tap[h][0] is the live pixel, tap[h][k] is the same column k rows up
    for (genvar h = 0; h < C; h++) begin : g_ch
        assign tap[h][0] = bus.pixel_in[h*DW +: DW];
        for (genvar k = 1; k < K; k++) begin : g_lb
            line_buffer #(
                .DATA_WIDTH(DW),
                .IMG_WIDTH (IMG_WIDTH)
            ) u_lb (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (accept),
                .din  (tap[h][k-1]),
                .dout (tap[h][k])
            );
        end
    end

    always_comb begin
        win_flat = '0;
        for (int h = 0; h < C; h++)
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_nx[h][r][c] = win[h][r][c+1];
                win_nx[h][r][K-1] = tap[h][K-1-r];
                for (int c = 0; c < K; c++) win_flat[(h*K*K + r*K + c)*DW +: DW] = win_nx[h][r][c];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col              <= '0;
            row              <= '0;
            bus.window_valid <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.window_out   <= '0;
            for (int h = 0; h < C; h++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++) win[h][r][c] <= '0;
        end else begin
            bus.window_valid <= win_hit;
            bus.frame_done   <= accept && last_row && last_col;
            if (accept) begin
                win <= win_nx;
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
            end
            if (win_hit) bus.window_out <= win_flat;
        end
    end

endmodule
